mod_uart_fifo: RTL and testbench

MOD_UART_FIFO -- requirements
Module: mod_uart_fifo

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_fifo.sv | 44 ++++
 rtl/mod_uart_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_mod_uart_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART block: register offsets, STATUS bit positions,
// CMD bit positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [31:0] ADDR_CMD    = 32'h00;
    localparam logic [31:0] ADDR_STATUS = 32'h04;
    localparam logic [31:0] ADDR_RXDATA = 32'h08;
    localparam logic [31:0] ADDR_TXDATA = 32'h0C;
    localparam logic [31:0] ADDR_DIV    = 32'h10;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_OVR       = 4;
    localparam int ST_FERR      = 5;

    localparam int CMD_POP = 0;
    localparam int CMD_CLR = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with one-bit-wider pointers; head entry is visible combinationally.
// A full FIFO accepts a push that coincides with a pop; an empty FIFO ignores pops.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(negedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mod_uart_fifo.sv
// Memory-mapped 8N1 UART with RX/TX FIFOs, baud16 tick generator and sticky
// overrun/framing flags. All state advances on the falling edge of clk.
module mod_uart_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int DEFAULT_DIV16 = 27
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        ie,
    input  logic        de,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic        drw,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout,
    output logic        txd,
    input  logic        rxd
);
    localparam logic [15:0] DIV_RESET = 16'(DEFAULT_DIV16);

    logic [15:0] div_q, div_act_q, tick_cnt_q;
    logic        tick, wr, rx_pop, flag_clr, tx_push, tx_pop;
    logic        rx_push, rx_stop_sample, rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]  rx_rdata, tx_rdata, tx_sh_q, rx_sh_q;
    logic        ovr_q, ferr_q;
    logic [1:0]  rxd_sync_q;
    logic        rxd_s;
    tx_state_e   tx_state_q;
    rx_state_e   rx_state_q;
    logic [3:0]  tx_tcnt_q, rx_tcnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [31:0] rdata, status;
    logic        unused_bits;

    assign unused_bits = ^{iaddr, din[31:16]};

    assign wr       = de && drw;
    assign rx_pop   = wr && (daddr == ADDR_CMD) && din[CMD_POP];
    assign flag_clr = wr && (daddr == ADDR_CMD) && din[CMD_CLR];
    assign tx_push  = wr && (daddr == ADDR_TXDATA);

    // The active divisor is only swapped when a tick completes, so a DIV write
    // never produces a short or stretched tick interval.
    assign tick = (tick_cnt_q == div_act_q - 16'd1);

    always_ff @(negedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            div_act_q  <= DIV_RESET;
            div_q      <= DIV_RESET;
        end else begin
            if (tick) begin
                tick_cnt_q <= '0;
                div_act_q  <= div_q;
            end else begin
                tick_cnt_q <= tick_cnt_q + 16'd1;
            end
            if (wr && (daddr == ADDR_DIV))
                div_q <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh_q), .pop(rx_pop),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .wdata(din[7:0]), .pop(tx_pop),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    // A waiting byte is taken either from IDLE or at the end of STOP (back-to-back frames).
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && (tx_tcnt_q == 4'd15)));

    always_ff @(negedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            txd        <= 1'b1;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            case (tx_state_q)
                TX_IDLE: begin
                    tx_tcnt_q <= '0;
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        txd        <= 1'b0;
                        tx_sh_q    <= tx_rdata;
                    end
                end
                TX_START: if (tx_tcnt_q == 4'd15) begin
                    tx_state_q <= TX_DATA;
                    txd        <= tx_sh_q[0];
                    tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                    tx_bit_q   <= '0;
                end
                TX_DATA: if (tx_tcnt_q == 4'd15) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TX_STOP;
                        txd        <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        txd      <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                    end
                end
                default: if (tx_tcnt_q == 4'd15) begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        txd        <= 1'b0;
                        tx_sh_q    <= tx_rdata;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    assign rxd_s          = rxd_sync_q[1];
    assign rx_stop_sample = tick && (rx_state_q == RX_STOP) && (rx_tcnt_q == 4'd15);
    assign rx_push        = rx_stop_sample && rxd_s && !rx_full;

    always_ff @(negedge clk) begin
        if (rst) begin
            rxd_sync_q <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rxd_sync_q <= {rxd_sync_q[0], rxd};
            if (tick) begin
                rx_tcnt_q <= rx_tcnt_q + 4'd1;
                case (rx_state_q)
                    RX_IDLE: begin
                        rx_tcnt_q <= '0;
                        if (!rxd_s) rx_state_q <= RX_START;
                    end
                    // Mid-start re-check rejects short low glitches on the idle line.
                    RX_START: if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (rx_tcnt_q == 4'd15) begin
                        rx_sh_q  <= {rxd_s, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end
                    default: if (rx_tcnt_q == 4'd15) rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // Set has priority over a simultaneous CMD clear.
    always_ff @(negedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (flag_clr) begin
                ovr_q  <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (rx_stop_sample && rxd_s && rx_full) ovr_q  <= 1'b1;
            if (rx_stop_sample && !rxd_s)           ferr_q <= 1'b1;
        end
    end

    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = !rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_OVR]       = ovr_q;
        status[ST_FERR]      = ferr_q;
    end

    always_comb begin
        rdata = '0;
        case (daddr)
            ADDR_STATUS: rdata = status;
            ADDR_RXDATA: rdata = rx_empty ? 32'd0 : {24'd0, rx_rdata};
            ADDR_DIV:    rdata = {16'd0, div_q};
            default:     rdata = '0;
        endcase
    end

    assign dout = de ? rdata : 32'hzzzz_zzzz;
    assign iout = ie ? 32'd0 : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mod_uart_fifo.sv
// Directed bench for mod_uart_fifo (FIFO_DEPTH=4): TX framing, back-to-back frames,
// RX receive, overrun, framing error, glitch reject and mid-frame reset.
module tb_mod_uart_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ie, de, drw, rxd;
    logic [31:0] iaddr, daddr, din;
    wire  [31:0] iout, dout;
    logic        txd;

    int tests_run    = 0;
    int tests_failed = 0;

    mod_uart_fifo #(.FIFO_DEPTH(4), .DEFAULT_DIV16(27)) dut (
        .rst(rst), .clk(clk), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
        .drw(drw), .din(din), .iout(iout), .dout(dout), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        de = 1'b1; drw = 1'b1; daddr = a; din = d;
        @(posedge clk);
        de = 1'b0; drw = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk);
        de = 1'b1; drw = 1'b0; daddr = a;
        #1;
        d  = dout;
        de = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic set_fast_div();
        bus_write(ADDR_DIV, 32'd0);
        repeat (30) @(posedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (16) @(posedge clk);
        rxd = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    // Waits for a start edge, then samples each bit mid-way; returns at mid stop bit.
    task automatic tx_capture(output logic [7:0] data, output int gap, output logic ok);
        logic s_bit, p_bit;
        gap  = 0;
        data = '0;
        ok   = 1'b0;
        do begin
            @(posedge clk);
            gap++;
        end while (txd !== 1'b0 && gap < 400);
        if (txd !== 1'b0) return;
        repeat (8) @(posedge clk);
        s_bit = txd;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            data[i] = txd;
        end
        repeat (16) @(posedge clk);
        p_bit = txd;
        ok = (s_bit == 1'b0) && (p_bit == 1'b1);
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  exp_tx [4];
        logic [7:0]  exp_rx [4];
        logic        ok;
        int          gap, lows;

        exp_tx = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        exp_rx = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; ie = 1'b0; de = 1'b0; drw = 1'b0; rxd = 1'b1;
        iaddr = '0; daddr = '0; din = '0;

        // Reset state and register map
        do_reset();
        read_check("rst_status", ADDR_STATUS, 32'h04);
        read_check("rst_div", ADDR_DIV, 32'd27);
        read_check("cmd_reads0", ADDR_CMD, 32'h0);
        read_check("rxdata_empty", ADDR_RXDATA, 32'h0);
        read_check("unmapped", 32'h14, 32'h0);
        @(posedge clk);
        ie = 1'b1; iaddr = 32'h8;
        #1 check("iout_zero", iout, 32'h0);
        ie = 1'b0;
        bus_write(32'h14, 32'hFFFF_FFFF);
        read_check("unmapped_wr_ignored", ADDR_STATUS, 32'h04);

        // DIV=0 stored as 1; single 0x55 frame
        set_fast_div();
        read_check("div_zero_is_one", ADDR_DIV, 32'd1);
        bus_write(ADDR_TXDATA, 32'h55);
        tx_capture(b, gap, ok);
        check("tx55_frame_ok", {31'd0, ok}, 32'd1);
        check("tx55_data", {24'd0, b}, 32'h55);
        repeat (16) @(posedge clk);
        read_check("tx55_status", ADDR_STATUS, 32'h04);
        read_check("txdata_reads0", ADDR_TXDATA, 32'h0);

        // Six writes into a depth-4 TX FIFO before the first (slow) tick
        do_reset();
        for (int i = 0; i < 6; i++) bus_write(ADDR_TXDATA, 32'hA1 + i);
        read_check("tx_full_status", ADDR_STATUS, 32'h08);
        bus_write(ADDR_DIV, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tx_capture(b, gap, ok);
            check($sformatf("burst%0d_ok", i), {31'd0, ok}, 32'd1);
            check($sformatf("burst%0d_data", i), {24'd0, b}, {24'd0, exp_tx[i]});
            if (i > 0) check($sformatf("burst%0d_gap", i), gap, 32'd8);
        end
        lows = 0;
        repeat (60) begin
            @(posedge clk);
            if (txd == 1'b0) lows++;
        end
        check("burst_no_extra_frame", lows, 32'd0);
        read_check("burst_status_end", ADDR_STATUS, 32'h04);

        // Single RX byte
        do_reset();
        set_fast_div();
        rx_send(8'hA3, 1'b1);
        read_check("rxA3_status", ADDR_STATUS, 32'h05);
        read_check("rxA3_data", ADDR_RXDATA, 32'hA3);
        bus_write(ADDR_CMD, 32'h01);
        read_check("rxA3_popped", ADDR_STATUS, 32'h04);

        // RX overrun: five bytes into a depth-4 FIFO
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        rx_send(8'h33, 1'b1);
        rx_send(8'h44, 1'b1);
        rx_send(8'h55, 1'b1);
        read_check("ovr_status", ADDR_STATUS, 32'h17);
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("ovr_pop%0d", i), ADDR_RXDATA, {24'd0, exp_rx[i]});
            bus_write(ADDR_CMD, 32'h01);
        end
        read_check("ovr_drained", ADDR_STATUS, 32'h14);
        bus_write(ADDR_CMD, 32'h02);
        read_check("ovr_cleared", ADDR_STATUS, 32'h04);

        // Framing error, then a short glitch on the idle line
        rx_send(8'h5A, 1'b0);
        read_check("ferr_status", ADDR_STATUS, 32'h24);
        bus_write(ADDR_CMD, 32'h02);
        read_check("ferr_cleared", ADDR_STATUS, 32'h04);
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        read_check("glitch_status", ADDR_STATUS, 32'h04);

        // Reset in the middle of a TX frame
        do_reset();
        set_fast_div();
        bus_write(ADDR_TXDATA, 32'hF0);
        lows = 0;
        while (txd !== 1'b0 && lows < 400) begin
            @(posedge clk);
            lows++;
        end
        check("midrst_started", {31'd0, txd}, 32'd0);
        repeat (20) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        check("midrst_txd", {31'd0, txd}, 32'd1);
        read_check("midrst_status", ADDR_STATUS, 32'h04);
        read_check("midrst_div", ADDR_DIV, 32'd27);
        read_check("midrst_rxdata", ADDR_RXDATA, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
